sync_fifo_prog: RTL and testbench

- Parametrised single-clock FIFO. Next generation of the 8-bit × 16 almost-flag FIFO.
- Generalised in data width and depth.
- Adds run-time programmable almost-full/almost-empty thresholds, an occupancy count output, and sticky overflow/underflow error flags with a clear input.
- Sits between a producer and a consumer in the same clock domain. Used as the standard buffer for streaming datapaths.

---
 rtl/sync_fifo_prog.sv | 120 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count and sticky overflow/underflow flags. Define FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  input  logic [CW-1:0]    af_level,
  input  logic [CW-1:0]    ae_level,
  input  logic             clr_err,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Handshake: wr_en/rd_en are requests sampled at the rising edge; a write is taken
  // only when !full and a read only when !empty, both judged on pre-edge state.
  // A rejected request has no side effect other than raising its sticky error flag.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error on the same edge as clr_err takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; zero while empty keeps the output quiet.
  assign dout = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [WIDTH-1:0] r_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dout = r_dout;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_level);
  assign almost_empty = (r_count <= ae_level);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog (registered-read build; FIFO_FWFT_EN adds a fall-through check).
module tb_sync_fifo_prog;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [CW-1:0]    af_level = CW'(14);
  logic [CW-1:0]    ae_level = CW'(2);
  logic [WIDTH-1:0] dout;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock edge; the model consumes the inputs as they were before the edge.
  task automatic step();
    int               sz = m_q.size();
    logic [WIDTH-1:0] d  = din;
    bit               f  = (sz == DEPTH);
    bit               e  = (sz == 0);
    bit               wa = wr_en && !f;
    bit               ra = rd_en && !e;
    bit               so = wr_en && f;
    bit               su = rd_en && e;
    bit               cl = clr_err;
    @(posedge clk);
    #1;
    if (ra) exp_q.push_back(m_q.pop_front());
    if (wa) m_q.push_back(d);
    m_ovf = so ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_udf = su ? 1'b1 : (cl ? 1'b0 : m_udf);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #2;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL reset count: got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset empty/full: got %b/%b want 1/0", empty, full); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset dout: got %h want 00", dout); end
    n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset errs: got %b/%b want 0/0", overflow, underflow); end
    n_vec++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_err++; $display("FAIL reset ae/af: got %b/%b want 1/0", almost_empty, almost_full); end
    af_level = '0;
    #1;
    n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL reset af_level0: got %b want 1", almost_full); end
    af_level = CW'(14);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 18; i++) begin
      wr_en = 1'b1;
      din   = WIDTH'(i);
      step();
      n_vec++; if (count !== CW'(m_q.size())) begin n_err++; $display("FAIL fill count w%0d: got %0d want %0d", i, count, m_q.size()); end
      n_vec++; if (almost_full !== (m_q.size() >= 14)) begin n_err++; $display("FAIL fill af w%0d: got %b", i, almost_full); end
      n_vec++; if (full !== (m_q.size() == DEPTH)) begin n_err++; $display("FAIL fill full w%0d: got %b", i, full); end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL fill ovf w%0d: got %b want %b", i, overflow, m_ovf); end
    end
    wr_en = 1'b0;
    n_vec++; if (count !== CW'(16) || overflow !== 1'b1) begin n_err++; $display("FAIL fill end: got cnt %0d ovf %b want 16 1", count, overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 18; i++) begin
      rd_en = 1'b1;
      step();
      if (exp_q.size() > 0) m_dout = exp_q.pop_front();
      n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL drain dout r%0d: got %h want %h", i, dout, m_dout); end
      n_vec++; if (count !== CW'(m_q.size())) begin n_err++; $display("FAIL drain count r%0d: got %0d want %0d", i, count, m_q.size()); end
      n_vec++; if (almost_empty !== (m_q.size() <= 2)) begin n_err++; $display("FAIL drain ae r%0d: got %b", i, almost_empty); end
      n_vec++; if (empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL drain empty r%0d: got %b", i, empty); end
      n_vec++; if (underflow !== m_udf) begin n_err++; $display("FAIL drain udf r%0d: got %b want %b", i, underflow, m_udf); end
    end
    rd_en = 1'b0;
    n_vec++; if (dout !== 8'h10 || underflow !== 1'b1) begin n_err++; $display("FAIL drain end: got %h %b want 10 1", dout, underflow); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL clr_err: got %b/%b want 0/0", overflow, underflow); end
  endtask

  task automatic test_wrap();
    int n_ops [4] = '{10, 10, 12, 12};
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < n_ops[p]; k++) begin
        wr_en = (p % 2 == 0);
        rd_en = (p % 2 == 1);
        din   = WIDTH'($urandom_range(0, 255));
        step();
        if (exp_q.size() > 0) begin
          m_dout = exp_q.pop_front();
          n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL wrap dout p%0d k%0d: got %h want %h", p, k, dout, m_dout); end
        end
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_vec++; if (count !== '0 || empty !== 1'b1) begin n_err++; $display("FAIL wrap end: got cnt %0d empty %b want 0 1", count, empty); end
  endtask

  task automatic test_simul();
    wr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = WIDTH'($urandom_range(0, 255));
      step();
    end
    rd_en = 1'b1;
    din   = 8'h3C;
    step();
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    n_vec++; if (count !== CW'(5)) begin n_err++; $display("FAIL simul mid count: got %0d want 5", count); end
    n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL simul mid dout: got %h want %h", dout, m_dout); end
    rd_en = 1'b0;
    while (m_q.size() < DEPTH) begin
      din = WIDTH'($urandom_range(0, 255));
      step();
    end
    rd_en   = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    n_vec++; if (count !== CW'(15)) begin n_err++; $display("FAIL simul full count: got %0d want 15", count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL simul full ovf: got %b want 1", overflow); end
    n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL simul full dout: got %h want %h", dout, m_dout); end
    wr_en = 1'b0;
    while (m_q.size() > 0) begin
      step();
      m_dout = exp_q.pop_front();
      n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL simul drain dout: got %h want %h", dout, m_dout); end
    end
    wr_en = 1'b1;
    din   = 8'h5A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_vec++; if (count !== CW'(1) || underflow !== 1'b1) begin n_err++; $display("FAIL simul empty: got cnt %0d udf %b want 1 1", count, underflow); end
    n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL simul empty dout: got %h want %h", dout, m_dout); end
  endtask

  task automatic test_thresh();
    wr_en = 1'b1;
    while (m_q.size() < 8) begin
      din = WIDTH'($urandom_range(0, 255));
      step();
    end
    wr_en = 1'b0;
    n_vec++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin n_err++; $display("FAIL thresh base: got af %b ae %b want 0 0", almost_full, almost_empty); end
    af_level = CW'(8);
    #1;
    n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL thresh af8: got %b want 1", almost_full); end
    ae_level = CW'(8);
    #1;
    n_vec++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL thresh ae8: got %b want 1", almost_empty); end
    af_level = CW'(17);
    #1;
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL thresh af17: got %b want 0", almost_full); end
    af_level = CW'(14);
    ae_level = CW'(2);
    #1;
    n_vec++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin n_err++; $display("FAIL thresh restore: got af %b ae %b want 0 0", almost_full, almost_empty); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1;
    din   = 8'h77;
    step();
    wr_en = 1'b0;
    n_vec++; if (count !== CW'(9)) begin n_err++; $display("FAIL mid pre count: got %0d want 9", count); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++; if (count !== '0 || empty !== 1'b1) begin n_err++; $display("FAIL mid rst count/empty: got %0d %b want 0 1", count, empty); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL mid rst dout: got %h want 00", dout); end
    n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL mid rst errs: got %b/%b want 0/0", overflow, underflow); end
    #2;
    rst = 1'b1;
    wr_en = 1'b1;
    din   = 8'hA5;
    step();
    wr_en = 1'b0;
`ifdef FIFO_FWFT_EN
    n_vec++; if (dout !== 8'hA5) begin n_err++; $display("FAIL fwft head: got %h want a5", dout); end
`else
    n_vec++; if (dout !== 8'h00 || count !== CW'(1)) begin n_err++; $display("FAIL post rst write: got %h cnt %0d want 00 1", dout, count); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    m_dout = exp_q.pop_front();
    n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL post rst read: got %h want %h", dout, m_dout); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_thresh();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
